// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - NCH-channel programmable clock divider with glitch-free shadowed reload
// Optional feature: define CLKDIV_SYNC_EN to add the 'sync' phase-alignment input.
module multi_clock_divider #(
    parameter int          NCH         = 2,
    parameter int          W           = 28,
    parameter int          CHW         = 1,
    parameter int unsigned DEFAULT_DIV = 24999999
) (
    input  logic             clk_50MHz,
    input  logic             set_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [W-1:0]     wr_div,
    input  logic             wr_mode,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   load_pend,
    output logic             wr_err
);

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
    localparam logic [CHW:0] NCH_L   = (CHW+1)'(NCH);

    // Per-channel counting state and shadow (pending) settings
    logic [W-1:0]   cnt    [NCH];
    logic [W-1:0]   div    [NCH];
    logic [W-1:0]   sh_div [NCH];
    logic [NCH-1:0] mode;
    logic [NCH-1:0] sh_mode;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] clk_r;
    logic [NCH-1:0] tick_r;
    logic           wr_err_r;

    logic           wr_hit;
    logic [NCH-1:0] sel;
    logic [W-1:0]   new_div  [NCH];
    logic [NCH-1:0] new_mode;

    // Decode the write target; a same-cycle write takes precedence over the shadow on apply
    always_comb begin
        wr_hit   = wr_en && ({1'b0, wr_ch} < NCH_L);
        sel      = '0;
        new_mode = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i]      = wr_hit && (wr_ch == CHW'(i));
            new_div[i]  = sel[i] ? wr_div : sh_div[i];
            new_mode[i] = sel[i] ? wr_mode : sh_mode[i];
        end
    end

    // Channel counters, reload at terminal count, and write-error pulse
    always_ff @(posedge clk_50MHz) begin
        if (set_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt[i]    <= '0;
                div[i]    <= DEF_DIV;
                sh_div[i] <= '0;
            end
            mode     <= '0;
            sh_mode  <= '0;
            pend     <= '0;
            clk_r    <= '0;
            tick_r   <= '0;
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_en && !wr_hit;
            for (int i = 0; i < NCH; i++) begin
`ifdef CLKDIV_SYNC_EN
                if (sync) begin
                    cnt[i]    <= '0;
                    clk_r[i]  <= 1'b0;
                    tick_r[i] <= 1'b0;
                    if (pend[i]) begin
                        div[i]  <= sh_div[i];
                        mode[i] <= sh_mode[i];
                        pend[i] <= 1'b0;
                    end
                end else
`endif
                if (en && (cnt[i] == div[i])) begin
                    cnt[i]    <= '0;
                    tick_r[i] <= 1'b1;
                    if (pend[i] || sel[i]) begin
                        div[i]   <= new_div[i];
                        mode[i]  <= new_mode[i];
                        pend[i]  <= 1'b0;
                        clk_r[i] <= new_mode[i];
                    end else begin
                        clk_r[i] <= mode[i] ? 1'b1 : ~clk_r[i];
                    end
                end else begin
                    if (en) begin
                        cnt[i] <= cnt[i] + W'(1);
                        if (mode[i]) clk_r[i] <= 1'b0;
                    end
                    tick_r[i] <= 1'b0;
                    if (sel[i]) begin
                        sh_div[i]  <= wr_div;
                        sh_mode[i] <= wr_mode;
                        pend[i]    <= 1'b1;
                    end
                end
            end
        end
    end

    assign clk_out   = clk_r;
    assign tick      = tick_r;
    assign load_pend = pend;
    assign wr_err    = wr_err_r;

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb/tb_multi_clock_divider.sv - directed self-checking bench for multi_clock_divider
module tb_multi_clock_divider;

    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int CHW = 2;

    logic             clk = 1'b0;
    logic             set_n, en, wr_en, wr_mode;
    logic [CHW-1:0]   wr_ch;
    logic [W-1:0]     wr_div;
    logic [NCH-1:0]   clk_out, tick, load_pend;
    logic             wr_err;
    logic             sync;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               k;

    always #10 clk = ~clk;

    multi_clock_divider #(.NCH(NCH), .W(W), .CHW(CHW), .DEFAULT_DIV(3)) dut (
        .clk_50MHz (clk),
        .set_n     (set_n),
        .en        (en),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .wr_mode   (wr_mode),
`ifdef CLKDIV_SYNC_EN
        .sync      (sync),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .load_pend (load_pend),
        .wr_err    (wr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wr(input logic [CHW-1:0] ch, input logic [W-1:0] d, input logic m);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = d;
        wr_mode = m;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_n = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0; sync = 1'b0;
        k = 0;
        step(); step();
        check("rst_tick", tick, 0);
        check("rst_clk", clk_out, 0);
        check("rst_pend", load_pend, 0);
        check("rst_err", wr_err, 0);

        // default divisor 3: tick every 4, clk_out period 8
        set_n = 1'b0; en = 1'b1; k = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("def_tick", tick, (k % 4 == 0) ? 2'b11 : 2'b00);
            check("def_clk", clk_out, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
        end

        // deferred load on ch1 at cnt = 1
        step();
        wr(1, 1, 1'b1);
        step(); wr_en = 1'b0;
        check("defer_pend18", load_pend, 2'b10);
        check("defer_tick18", tick, 2'b00);
        step();
        check("defer_pend19", load_pend, 2'b10);
        step();
        check("defer_tick20", tick, 2'b11);
        check("defer_clk20", clk_out, 2'b11);
        check("defer_pend20", load_pend, 2'b00);
        for (int i = 21; i <= 28; i++) begin
            step();
            check("pulse_tick", tick, {k % 2 == 0, k % 4 == 0});
            check("pulse_clk", clk_out, {k % 2 == 0, (k / 4) % 2 == 1});
        end

        // overwrite: div 5 then div 2 before terminal count, div 2 wins
        step();
        wr(0, 5, 1'b0);
        step();
        check("ovw_pend30", load_pend, 2'b01);
        wr(0, 2, 1'b0);
        step(); wr_en = 1'b0;
        check("ovw_pend31", load_pend, 2'b01);
        step();
        check("ovw_tick32", tick, 2'b11);
        check("ovw_clk32", clk_out, 2'b10);
        check("ovw_pend32", load_pend, 2'b00);
        for (int i = 33; i <= 38; i++) begin
            step();
            check("div2_tick0", tick[0], ((k - 32) % 3 == 0));
            check("div2_clk0", clk_out[0], (((k - 32) / 3) % 2 == 1));
        end

        // write on the terminal-count cycle: div 0 applies immediately
        step(); step();
        wr(0, 0, 1'b0);
        step(); wr_en = 1'b0;
        check("same_pend41", load_pend[0], 1'b0);
        check("same_tick41", tick[0], 1'b1);
        check("same_clk41", clk_out[0], 1'b0);
        for (int i = 42; i <= 46; i++) begin
            step();
            check("div0_tick0", tick[0], 1'b1);
            check("div0_clk0", clk_out[0], (k - 41) % 2);
        end

        // out-of-range write
        wr(3, 7, 1'b1);
        step(); wr_en = 1'b0;
        check("err_pulse", wr_err, 1'b1);
        check("err_pend", load_pend, 2'b00);
        check("err_clk0_47", clk_out[0], 1'b0);
        step();
        check("err_clear", wr_err, 1'b0);
        check("err_clk0_48", clk_out[0], 1'b1);
        check("err_tick48", tick, 2'b11);

        // enable hold for 5 cycles with ch1 at cnt = 1
        step();
        check("hold_tick49", tick, 2'b01);
        check("hold_clk49", clk_out, 2'b00);
        en = 1'b0;
        for (int i = 50; i <= 54; i++) begin
            step();
            check("hold_tick", tick, 2'b00);
            check("hold_clk", clk_out, 2'b00);
        end
        en = 1'b1;
        step();
        check("resume_tick55", tick, 2'b11);
        check("resume_clk55", clk_out, 2'b11);

        // reset with a pending write on ch1
        wr(1, 9, 1'b1);
        step(); wr_en = 1'b0;
        check("rpend_56", load_pend, 2'b10);
        set_n = 1'b1;
        step();
        check("rmid_tick", tick, 2'b00);
        check("rmid_clk", clk_out, 2'b00);
        check("rmid_pend", load_pend, 2'b00);
        check("rmid_err", wr_err, 1'b0);
        set_n = 1'b0;
        for (int i = 58; i <= 66; i++) begin
            step();
            check("post_tick", tick, ((k - 57) % 4 == 0) ? 2'b11 : 2'b00);
            check("post_clk", clk_out, (((k - 57) / 4) % 2 == 1) ? 2'b11 : 2'b00);
            check("post_pend", load_pend, 2'b00);
        end

`ifdef CLKDIV_SYNC_EN
        // sync applies the pending ch1 shadow and zeroes both counters
        wr(1, 2, 1'b0);
        step(); wr_en = 1'b0;
        check("sync_pend67", load_pend, 2'b10);
        sync = 1'b1;
        step(); sync = 1'b0;
        check("sync_tick68", tick, 2'b00);
        check("sync_clk68", clk_out, 2'b00);
        check("sync_pend68", load_pend, 2'b00);
        step();
        check("sync_tick69", tick, 2'b00);
        step();
        check("sync_tick70", tick, 2'b00);
        step();
        check("sync_tick71", tick, 2'b10);
        step();
        check("sync_tick72", tick, 2'b01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised, multi-channel successor to the team's fixed 1 Hz clock divider. It derives NCH independent divided outputs from the 50 MHz system clock. Each channel has a run-time programmable divisor and mode: 50 % square wave or single-cycle tick. New settings are loaded through a write port and applied glitch-free at the channel's next terminal count. The block feeds the display refresh, blink and countdown timing logic.

## Interface
- NCH, 2, number of divider channels (1..16)
- W, 28, counter/divisor width in bits
- CHW, 1, width of channel select; must satisfy 2^CHW >= NCH
- DEFAULT_DIV, 24999999, reset divisor of every channel (terminal count; half-period minus 1 in toggle mode)
- clk_50MHz  input  1  system clock; all logic on rising edge
- set_n  input  1  reset, synchronous, active-high (despite the name)
- en  input  1  global count enable
- wr_en  input  1  write strobe, one cycle per write
- wr_ch  input  CHW  target channel
- wr_div  input  W  new terminal count
- wr_mode  input  1  new mode: 0 = toggle (square), 1 = pulse
- clk_out  output  NCH  per-channel divided output
- tick  output  NCH  per-channel one-cycle pulse at terminal count
- load_pend  output  NCH  per-channel flag: shadow settings waiting to apply
- wr_err  output  1  one-cycle pulse: write to a nonexistent channel

## Operation
- Per channel state: cnt[W], div[W], mode, shadow div/mode, pend, clk_out, tick.
- Reset (set_n = 1 at an edge): cnt = 0, div = DEFAULT_DIV, mode = toggle, pend = 0, clk_out = 0, tick = 0, wr_err = 0. Reset overrides every other input.
- Counting (en = 1):
  - If cnt != div: cnt <= cnt + 1, tick <= 0.
  - If cnt == div (terminal count): cnt <= 0 and tick <= 1.
  - In toggle mode, clk_out also inverts at terminal count.
  - In pulse mode, clk_out <= 1 at terminal count, else 0.
- Periods: toggle mode clk_out period is 2·(div+1) cycles at 50 % duty. Pulse mode period is div+1 cycles.
- div = 0: tick stays high continuously; toggle-mode clk_out = clk_50MHz/2.
- Hold (en = 0): cnt, clk_out and pend hold; tick <= 0. Writes are still accepted.
- Write: wr_en with wr_ch < NCH stores wr_div/wr_mode in the channel shadow and sets pend.
  - A write while pend is already set overwrites the shadow; last write wins.
- Out-of-range write: wr_ch >= NCH is ignored, and wr_err pulses for 1 cycle.
- Apply: at a terminal count with pend set, div <= shadow div, mode <= shadow mode, pend <= 0, cnt <= 0.
- Write in the same cycle as a terminal count: the written values are applied at that terminal count directly, and pend ends at 0.
- Mode change on apply: clk_out <= 0 in toggle mode and <= 1 in pulse mode. tick still pulses.
- Counter arithmetic is unsigned W-bit. cnt never exceeds div, because a smaller applied div takes effect only when cnt resets to 0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- After reset release with en held high, edge k sets cnt = k for k ≤ div. tick rises after edge div+1 and is high for exactly 1 cycle. The first toggle-mode clk_out rise occurs at the same edge.
- Write latency: load_pend and wr_err assert 1 cycle after the wr_en edge. The new period takes effect from the next terminal count, which is at most old div+1 enabled cycles later.
- Reset mid-operation discards pending shadows. Outputs read reset values 1 cycle after the reset edge.

## Configuration
- CLKDIV_SYNC_EN defined: adds input port sync (1 bit).
  - With sync = 1 and set_n = 0, every channel gets cnt <= 0, clk_out <= 0 and tick <= 0, which phase-aligns all channels.
  - Any pending shadow is applied immediately and pend cleared.
  - Priority: set_n > sync > write/count.
- CLKDIV_SYNC_EN undefined: no sync port and no such behaviour.

## Test plan
- Reset/default: NCH = 2, DEFAULT_DIV = 3, en = 1 → tick on both channels every 4 cycles, clk_out period 8 cycles at 50 % duty, load_pend = 0.
- Deferred load: at cnt = 1 write ch1 div = 1, mode = 1 → load_pend[1] = 1 until the next terminal count 2 cycles later. After that, tick[1] = clk_out[1] pulse every 2 cycles; ch0 is unaffected.
- Same-cycle and overwrite:
  - Write ch0 div = 5, then div = 2 before its terminal count → div 2 applies.
  - A write on the terminal-count cycle applies there, with load_pend[0] staying 0.
- Edge cases:
  - div = 0 in toggle mode → clk_out toggles every cycle and tick is constant 1.
  - wr_ch = 3 with NCH = 2 → wr_err pulses for 1 cycle and no channel changes.
- Enable/reset: deassert en for 5 cycles mid-count → cnt and clk_out frozen, tick = 0, and counting resumes from the held value. Assert set_n with a pending write → all outputs reset and the pending write is lost.
- With CLKDIV_SYNC_EN: pulse sync with channels at different phases → the next ticks of both channels coincide.
